boton_evento_ctrl: RTL
======================

Name: boton_evento_ctrl

Overview:
- Sits between the per-button debounce instances (`boton_antirrebote`) and the game/menu FSM.
- Watches N debounced button levels and classifies each press as short or long.
- Arbitrates simultaneous events round-robin and queues them in a small FIFO.
- Delivers one event at a time over a valid/ready handshake, so the FSM never misses or double-counts a press.

Parameters:
- N_BTN, 4, number of debounced buttons (2..8).
- LONG_CYCLES, 8, hold length in clk cycles that qualifies a long press (>=2); 50_000_000 for 1 s on hardware.
- FIFO_DEPTH, 4, event queue depth (power of 2, >=2).
- REPEAT_CYCLES, 4, auto-repeat period; only used with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_db  in  N_BTN  debounced button levels, 1 = pressed; synchronous to clk.
- ev_valid  out  1  head of FIFO holds an event.
- ev_ready  in  1  consumer accepts the event.
- ev_id  out  $clog2(N_BTN)  button index of the head event.
- ev_long  out  1  head event is a long press (1) or a short press (0).
- ev_overflow  out  1  sticky; an event was dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued events.

Behaviour:
- Reset (async, active-high):
  - All outputs 0.
  - FIFO empty; all pending flags 0; round-robin pointer 0; all button FSMs IDLE.
  - Previous-level register btn_prev resets to all ones, so a button held through reset produces nothing until it is released and pressed again.
- Per-button FSM, states IDLE / PRESSED / HELD:
  - IDLE -> PRESSED when btn_db=1 and btn_prev=0; hold counter cleared to 0.
  - PRESSED: counter increments every cycle while btn_db=1.
  - PRESSED -> HELD when counter reaches LONG_CYCLES-1; generates a long event that same edge.
  - PRESSED -> IDLE on btn_db=0; generates a short event.
  - HELD -> IDLE on btn_db=0; no event.
  - Counter width is $clog2(LONG_CYCLES); it saturates and never wraps.
- Pending stage:
  - A generated event sets pend[i] and pend_long[i] on the same edge.
  - If pend[i] is already set, the new event is dropped and ev_overflow is set to 1.
  - ev_overflow stays set until reset.
- Arbiter:
  - Each cycle with FIFO not full, grants one pend[i]: the first set index at or after rr_ptr, wrapping.
  - The grant pushes {i, pend_long[i]} into the FIFO, clears pend[i], and sets rr_ptr = i+1 mod N_BTN.
  - An event generated on the same edge as a grant for that button is captured into pend[i]; no overflow.
  - FIFO full: no grant; events wait in pend.
  - Push uses the current-cycle full flag; a simultaneous pop does not allow a push into a full FIFO.
- FIFO / handshake:
  - ev_valid = !empty; ev_id and ev_long come from the head entry.
  - Pop on ev_valid && ev_ready.
  - Push and pop in the same cycle are allowed when not full; fifo_level is unchanged.
  - ev_id and ev_long stay stable while ev_valid=1 and ev_ready=0.
- Latency:
  - Edge k: the release (or LONG_CYCLES-th held cycle) is sampled and pend is set.
  - Edge k+1: the event is pushed.
  - ev_valid=1 after edge k+1, when the FIFO was empty and no other pending event wins arbitration.
- Reset mid-operation: all state is discarded immediately, including queued events and pending flags.

Optional Feature:
- Macro: BOTON_AUTOREPEAT_EN.
- Defined:
  - In HELD, a second counter emits an additional long event every REPEAT_CYCLES cycles while the button stays held.
  - The first repeat comes REPEAT_CYCLES cycles after the initial long event.
  - Repeats obey the same pending/overflow rules.
- Undefined: HELD emits nothing; no repeat counter logic exists.

Test Plan:
- Short press: N_BTN=4, LONG_CYCLES=8, ev_ready=1; btn_db[1]=1 for 3 cycles then 0 -> exactly one event, ev_id=1, ev_long=0, ev_valid high for 1 cycle, 2 edges after the release sample.
- Long press: btn_db[2] held 12 cycles -> one event, ev_id=2, ev_long=1, generated on the 8th held cycle; release produces no event; ev_overflow=0.
- Round-robin: short press on button 0 alone -> grant 0, rr_ptr=1. Then buttons 0 and 3 released on the same edge -> ev_id=3 first, ev_id=0 on the next cycle.
- Backpressure/overflow: ev_ready=0, six short presses on button 1 -> fifo_level=4, pend[1]=1 after the 5th, ev_overflow=1 after the 6th. Then ev_ready=1 -> exactly 5 events drained, all ev_id=1, ev_long=0; fifo_level returns to 0.
- Reset mid-hold: btn_db[0] held 5 cycles, reset pulsed, button still held 10 more cycles, then released -> no events; all outputs 0 during reset. Next press/release of button 0 -> one short event.
- With BOTON_AUTOREPEAT_EN and REPEAT_CYCLES=4: btn_db[3] held 20 cycles -> long events generated at held cycles 8, 12, 16 and 20 (4 events, ev_id=3, ev_long=1); ev_overflow=0 with ev_ready=1.

Source files
------------

// File: rtl/boton_evento_ctrl.sv
// boton_evento_ctrl: classifies debounced button presses as short/long, arbitrates them
// round-robin into a small event FIFO with a valid/ready output. Optional: BOTON_AUTOREPEAT_EN.
module boton_evento_ctrl #(
  parameter int N_BTN         = 4,
  parameter int LONG_CYCLES   = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [N_BTN-1:0]              btn_db_i,
  output logic                          ev_valid_o,
  input  logic                          ev_ready_i,
  output logic [$clog2(N_BTN)-1:0]      ev_id_o,
  output logic                          ev_long_o,
  output logic                          ev_overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  // state   | meaning
  // IDLE    | released, or held since before reset
  // PRESSED | fresh press, counting hold length
  // HELD    | long event already issued, waiting for release
  localparam int IW = $clog2(N_BTN);
  localparam int CW = $clog2(LONG_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FIRE = CW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} btn_st_e;

  btn_st_e          st_q  [N_BTN];
  btn_st_e          st_d  [N_BTN];
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] btn_prev_q;
  logic [N_BTN-1:0] ev_gen, ev_gen_long;
`ifdef BOTON_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0]    rep_q [N_BTN];
  logic [RW-1:0]    rep_d [N_BTN];
`endif

  logic [N_BTN-1:0] pend_q, pend_d, pend_long_q, pend_long_d;
  logic [IW-1:0]    rr_q, rr_d, gnt_idx;
  logic [IW:0]      scan;
  logic             gnt_found, push, pop, full;
  logic             ovf_q, ovf_d;
  logic [IW:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;

  always_comb begin
    ev_gen      = '0;
    ev_gen_long = '0;
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
`ifdef BOTON_AUTOREPEAT_EN
      rep_d[i] = rep_q[i];
`endif
      unique case (st_q[i])
        IDLE: begin
          if (btn_db_i[i] && !btn_prev_q[i]) begin
            st_d[i]  = PRESSED;
            cnt_d[i] = '0;
          end
        end
        PRESSED: begin
          if (!btn_db_i[i]) begin
            st_d[i]   = IDLE;
            ev_gen[i] = 1'b1;
          end else begin
            if (cnt_q[i] != CNT_LAST) cnt_d[i] = cnt_q[i] + 1'b1;
            if (cnt_q[i] == CNT_FIRE) begin
              st_d[i]        = HELD;
              ev_gen[i]      = 1'b1;
              ev_gen_long[i] = 1'b1;
`ifdef BOTON_AUTOREPEAT_EN
              rep_d[i]       = '0;
`endif
            end
          end
        end
        HELD: begin
          if (!btn_db_i[i]) st_d[i] = IDLE;
`ifdef BOTON_AUTOREPEAT_EN
          else if (rep_q[i] == REP_LAST) begin
            rep_d[i]       = '0;
            ev_gen[i]      = 1'b1;
            ev_gen_long[i] = 1'b1;
          end else rep_d[i] = rep_q[i] + 1'b1;
`endif
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  // Round-robin: first pending index at or after rr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < N_BTN; k++) begin
      scan = {1'b0, rr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N_BTN)) scan = scan - (IW+1)'(N_BTN);
      if (!gnt_found && pend_q[scan[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IW-1:0];
      end
    end
  end

  assign full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push = gnt_found && !full;
  assign pop  = ev_valid_o && ev_ready_i;

  // A grant frees the slot before new events land, so same-edge capture is not an overflow.
  always_comb begin
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    ovf_d       = ovf_q;
    rr_d        = rr_q;
    if (push) begin
      pend_d[gnt_idx] = 1'b0;
      rr_d = (gnt_idx == IW'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (ev_gen[i]) begin
        if (pend_d[i]) ovf_d = 1'b1;
        else begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = ev_gen_long[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_prev_q  <= '1;
      pend_q      <= '0;
      pend_long_q <= '0;
      rr_q        <= '0;
      ovf_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
`ifdef BOTON_AUTOREPEAT_EN
        rep_q[i] <= '0;
`endif
      end
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      btn_prev_q  <= btn_db_i;
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      rr_q        <= rr_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef BOTON_AUTOREPEAT_EN
        rep_q[i] <= rep_d[i];
`endif
      end
      if (push) begin
        mem_q[wr_q] <= {gnt_idx, pend_long_q[gnt_idx]};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign ev_valid_o           = (count_q != '0);
  assign {ev_id_o, ev_long_o} = mem_q[rd_q];
  assign ev_overflow_o        = ovf_q;
  assign fifo_level_o         = count_q;

endmodule
